// File: rtl/bpu_mem_io_hub.sv
// BatPU2 data-port hub: synchronous RAM below IO_BASE, memory-mapped
// output/input/change-flag/mask registers above it.
module bpu_mem_io_hub #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int IO_BASE     = 248,
  parameter int N_OUT       = 2,
  parameter int N_IN        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rvalid,
  input  logic [N_IN*DATA_W-1:0]  in_ports,
  output logic [N_OUT*DATA_W-1:0] out_ports,
  output logic [N_OUT-1:0]        out_strobe,
  output logic                    irq
);

  localparam int CHG_O  = N_OUT + N_IN;
  localparam int MASK_O = CHG_O + 1;
  localparam int RA_W   = (IO_BASE > 1) ? $clog2(IO_BASE) : 1;
  localparam logic [ADDR_W-1:0] IO_B = ADDR_W'(IO_BASE);

  if (N_OUT + N_IN + 2 > (2**ADDR_W) - IO_BASE) begin : g_map_chk
    $error("I/O window too small for register map");
  end

  logic [DATA_W-1:0] ram [IO_BASE];

  logic [SYNC_STAGES-1:0][N_IN*DATA_W-1:0] sync_q;
  logic [N_IN*DATA_W-1:0]       in_sync;
  logic [N_IN*DATA_W-1:0]       prev_q;
  logic [N_OUT-1:0][DATA_W-1:0] out_q;
  logic [N_IN-1:0]              chg_q;
  logic [N_IN-1:0]              mask_q;

  logic              is_io;
  logic [ADDR_W-1:0] off;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] rd_val;
  logic [N_OUT-1:0]  out_we;
  logic [N_IN-1:0]   chg_new;
  logic [N_IN-1:0]   chg_clr;
  logic              mask_we;

  assign is_io     = addr >= IO_B;
  assign off       = addr - IO_B;
  assign rd        = mem_req & ~mem_we;
  assign wr        = mem_req & mem_we;
  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign out_ports = out_q;
  assign irq       = |(chg_q & mask_q);

  always_comb begin
    rd_val = '0;
    if (!is_io) begin
      rd_val = ram[addr[RA_W-1:0]];
    end else begin
      for (int i = 0; i < N_OUT; i++)
        if (off == ADDR_W'(i)) rd_val = out_q[i];
      for (int i = 0; i < N_IN; i++)
        if (off == ADDR_W'(N_OUT + i))
          rd_val = in_sync[i*DATA_W +: DATA_W];
      if (off == ADDR_W'(CHG_O))  rd_val[N_IN-1:0] = chg_q;
      if (off == ADDR_W'(MASK_O)) rd_val[N_IN-1:0] = mask_q;
    end
  end

  always_comb begin
    out_we  = '0;
    chg_clr = '0;
    chg_new = '0;
    mask_we = 1'b0;
    for (int i = 0; i < N_OUT; i++)
      out_we[i] = wr & is_io & (off == ADDR_W'(i));
    if (wr && is_io && off == ADDR_W'(CHG_O))
      chg_clr = wdata[N_IN-1:0];
    mask_we = wr & is_io & (off == ADDR_W'(MASK_O));
    for (int i = 0; i < N_IN; i++)
      chg_new[i] = in_sync[i*DATA_W +: DATA_W]
                != prev_q[i*DATA_W +: DATA_W];
  end

  // Synchronisers ignore clk_en so pin activity is never lost in a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= in_ports;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && wr && !is_io)
      ram[addr[RA_W-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata      <= '0;
      rvalid     <= 1'b0;
      out_q      <= '0;
      out_strobe <= '0;
      prev_q     <= '0;
      chg_q      <= '0;
      mask_q     <= '0;
    end else if (clk_en) begin
      rvalid     <= rd;
      out_strobe <= out_we;
      prev_q     <= in_sync;
      // New change beats a same-edge W1C
      chg_q      <= (chg_q & ~chg_clr) | chg_new;
      if (rd) rdata <= rd_val;
      for (int i = 0; i < N_OUT; i++)
        if (out_we[i]) out_q[i] <= wdata;
      if (mask_we) mask_q <= wdata[N_IN-1:0];
    end
  end

endmodule

// File: tb/tb_bpu_mem_io_hub.sv
// Directed bench for bpu_mem_io_hub: vector table plus hand-written
// sequences for reset, input/IRQ and stall behaviour.
module tb_bpu_mem_io_hub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [7:0]  addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [15:0] in_ports = '0;
  logic [15:0] out_ports;
  logic [1:0]  out_strobe;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  bpu_mem_io_hub dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .mem_req(mem_req), .mem_we(mem_we),
    .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid),
    .in_ports(in_ports), .out_ports(out_ports),
    .out_strobe(out_strobe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        req;
    logic        we;
    logic [7:0]  a;
    logic [7:0]  wd;
    logic        rv;
    logic [7:0]  rd;
    logic [1:0]  stb;
    logic [15:0] outp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic en, logic req, logic we,
                       logic [7:0] a, logic [7:0] wd);
    clk_en  = en;
    mem_req = req;
    mem_we  = we;
    addr    = a;
    wdata   = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // en req we addr wd | rvalid rdata strobe out_ports
    tbl.push_back('{1,1,1,8'h10,8'h5A, 0,8'h00,2'b00,16'h0000});
    tbl.push_back('{1,1,0,8'h10,8'h00, 1,8'h5A,2'b00,16'h0000});
    tbl.push_back('{1,1,1,8'hF7,8'h77, 0,8'h5A,2'b00,16'h0000});
    tbl.push_back('{1,1,0,8'hF7,8'h00, 1,8'h77,2'b00,16'h0000});
    tbl.push_back('{1,1,1,8'hF8,8'h11, 0,8'h77,2'b01,16'h0011});
    tbl.push_back('{1,1,0,8'hF8,8'h00, 1,8'h11,2'b00,16'h0011});
    tbl.push_back('{1,1,1,8'hF9,8'hC3, 0,8'h11,2'b10,16'hC311});
    tbl.push_back('{1,0,0,8'h00,8'h00, 0,8'h11,2'b00,16'hC311});
    tbl.push_back('{1,1,0,8'hF9,8'h00, 1,8'hC3,2'b00,16'hC311});
    tbl.push_back('{1,1,1,8'hFE,8'hFF, 0,8'hC3,2'b00,16'hC311});
    tbl.push_back('{1,1,0,8'hFE,8'h00, 1,8'h00,2'b00,16'hC311});
    tbl.push_back('{1,1,1,8'hFA,8'h55, 0,8'h00,2'b00,16'hC311});
    tbl.push_back('{1,1,0,8'hFA,8'h00, 1,8'h00,2'b00,16'hC311});
    tbl.push_back('{1,1,1,8'hFD,8'hFF, 0,8'h00,2'b00,16'hC311});
    tbl.push_back('{1,1,0,8'hFD,8'h00, 1,8'h03,2'b00,16'hC311});
    tbl.push_back('{1,1,0,8'hFC,8'h00, 1,8'h00,2'b00,16'hC311});
    tbl.push_back('{1,1,1,8'hFD,8'h00, 0,8'h00,2'b00,16'hC311});
    tbl.push_back('{1,1,0,8'hF8,8'h00, 1,8'h11,2'b00,16'hC311});
    tbl.push_back('{0,1,1,8'hF8,8'h99, 1,8'h11,2'b00,16'hC311});
    tbl.push_back('{0,1,0,8'h10,8'h00, 1,8'h11,2'b00,16'hC311});
    tbl.push_back('{1,1,0,8'hF8,8'h00, 1,8'h11,2'b00,16'hC311});
    tbl.push_back('{1,1,0,8'hFF,8'h00, 1,8'h00,2'b00,16'hC311});
    tbl.push_back('{1,1,1,8'hF8,8'h22, 0,8'h00,2'b01,16'hC322});
    tbl.push_back('{0,0,0,8'h00,8'h00, 0,8'h00,2'b01,16'hC322});
    tbl.push_back('{1,0,0,8'h00,8'h00, 0,8'h00,2'b00,16'hC322});

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_out", out_ports, 0);
    chk("rst_strobe", out_strobe, 0);
    chk("rst_irq", irq, 0);
    #3 rst_n = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].en, tbl[k].req, tbl[k].we, tbl[k].a, tbl[k].wd);
      tick();
      chk($sformatf("v%0d_rvalid", k), rvalid, tbl[k].rv);
      chk($sformatf("v%0d_rdata", k), rdata, tbl[k].rd);
      chk($sformatf("v%0d_strobe", k), out_strobe, tbl[k].stb);
      chk($sformatf("v%0d_out", k), out_ports, tbl[k].outp);
      chk($sformatf("v%0d_irq", k), irq, 0);
    end

    // Input change through the synchroniser raises CHG/irq
    drive(1, 1, 1, 8'hFD, 8'h01);
    tick();
    drive(1, 0, 0, 8'h00, 8'h00);
    in_ports = 16'h0080;
    tick();
    tick();
    chk("irq_early", irq, 0);
    tick();
    chk("irq_set", irq, 1);
    drive(1, 1, 0, 8'hFA, 8'h00);
    tick();
    chk("in0_read", rdata, 8'h80);
    drive(1, 1, 0, 8'hFC, 8'h00);
    tick();
    chk("chg_read", rdata, 8'h01);
    drive(1, 1, 1, 8'hFC, 8'h01);
    tick();
    chk("irq_w1c", irq, 0);

    // W1C lands on the same edge as a fresh change: set wins
    drive(1, 0, 0, 8'h00, 8'h00);
    in_ports = 16'h0000;
    tick();
    tick();
    drive(1, 1, 1, 8'hFC, 8'h01);
    tick();
    chk("irq_setwins", irq, 1);
    drive(1, 1, 0, 8'hFC, 8'h00);
    tick();
    chk("chg_setwins", rdata, 8'h01);
    drive(1, 1, 1, 8'hFC, 8'h03);
    tick();
    drive(1, 1, 0, 8'hFC, 8'h00);
    tick();
    chk("chg_clear", rdata, 8'h00);

    // Stall after a read; pin toggles during the stall
    drive(1, 1, 0, 8'h10, 8'h00);
    tick();
    chk("stall_pre_rv", rvalid, 1);
    chk("stall_pre_rd", rdata, 8'h5A);
    drive(0, 0, 0, 8'h00, 8'h00);
    in_ports = 16'h0100;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("stall%0d_rv", c), rvalid, 1);
      chk($sformatf("stall%0d_rd", c), rdata, 8'h5A);
    end
    drive(1, 0, 0, 8'h00, 8'h00);
    tick();
    chk("stall_post_rv", rvalid, 0);
    chk("stall_post_rd", rdata, 8'h5A);
    drive(1, 1, 0, 8'hFC, 8'h00);
    tick();
    chk("stall_chg", rdata, 8'h02);
    chk("stall_irq", irq, 0);

    // Reset in mid-stream with a strobe pending
    in_ports = 16'h0000;
    drive(1, 1, 1, 8'hF9, 8'h44);
    tick();
    chk("mid_strobe", out_strobe, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rdata", rdata, 0);
    chk("mid_rvalid", rvalid, 0);
    chk("mid_out", out_ports, 0);
    chk("mid_strobe0", out_strobe, 0);
    chk("mid_irq", irq, 0);
    #2 rst_n = 1'b1;
    drive(1, 1, 0, 8'hF9, 8'h00);
    tick();
    chk("post_rst_rv", rvalid, 1);
    chk("post_rst_out1", rdata, 8'h00);
    drive(1, 1, 0, 8'hF8, 8'h00);
    tick();
    chk("post_rst_out0", rdata, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
